// File: rtl/sdram_ring_writer.sv
`default_nettype none
// ============================================================================
// Module   : sdram_ring_writer
// Brief    : Buffers a 32-bit capture stream in a show-ahead FIFO and writes it
//            as bursts into a circular SDRAM region via the sdrc_core app port.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_ring_writer #(
    parameter int          FIFO_DEPTH = 64,
    parameter int          BURST_LEN  = 8,
    parameter logic [25:0] RING_BASE  = 26'h100000,
    parameter logic [25:0] RING_SIZE  = 26'h100000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [31:0]                 in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        flush,
    output logic                        app_req,
    output logic [25:0]                 app_req_addr,
    output logic [8:0]                  app_req_len,
    output logic                        app_req_wr_n,
    input  logic                        app_req_ack,
    output logic [31:0]                 app_wr_data,
    output logic [3:0]                  app_wr_en_n,
    input  logic                        app_wr_next_req,
    output logic [25:0]                 wr_ptr,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        idle
);

    localparam int          c_aw       = $clog2(FIFO_DEPTH);
    localparam logic [26:0] c_ring_end = {1'b0, RING_BASE} + {1'b0, RING_SIZE};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    state_t          state_q,    state_d;
    logic            app_req_q,  app_req_d;
    logic [25:0]     req_addr_q, req_addr_d;
    logic [8:0]      req_len_q,  req_len_d;
    logic            req_wr_n_q, req_wr_n_d;
    logic [3:0]      wr_en_n_q,  wr_en_n_d;
    logic [25:0]     wr_ptr_q,   wr_ptr_d;
    logic [8:0]      beat_q,     beat_d;
    logic [c_aw:0]   level_q,    level_d;
    logic [c_aw-1:0] rd_idx_q,   rd_idx_d;
    logic [c_aw-1:0] wr_idx_q,   wr_idx_d;
    logic [31:0]     fifo_mem [FIFO_DEPTH];

    logic        w_push;
    logic        w_pop;
    logic        w_start;
    logic [8:0]  w_len;
    logic [8:0]  w_beat_inc;
    logic [26:0] w_room;
    logic [26:0] w_ptr_sum;

    assign w_push = in_valid && in_ready;
    assign w_pop  = (state_q == ST_XFER) && app_wr_next_req;

    always_comb begin
        rd_idx_d = rd_idx_q;
        wr_idx_d = wr_idx_q;
        level_d  = level_q;
        if (w_push) wr_idx_d = wr_idx_q + 1'b1;
        if (w_pop)  rd_idx_d = rd_idx_q + 1'b1;
        if (w_push && !w_pop)      level_d = level_q + 1'b1;
        else if (!w_push && w_pop) level_d = level_q - 1'b1;
    end

    // Storage carries no reset: stale entries are unreachable once level is zero.
    always_ff @(posedge clk) begin
        if (w_push) fifo_mem[wr_idx_q] <= in_data;
    end

    // Burst length is clamped by what is buffered and by the room left before the ring end.
    always_comb begin
        w_room = c_ring_end - {1'b0, wr_ptr_q};
        w_len  = 9'(BURST_LEN);
        if (27'(level_q) < 27'(w_len)) w_len = 9'(level_q);
        if (w_room < 27'(w_len))       w_len = w_room[8:0];
    end

    assign w_start    = (27'(level_q) >= 27'(BURST_LEN)) || (flush && (level_q != '0));
    assign w_beat_inc = beat_q + 9'd1;
    assign w_ptr_sum  = {1'b0, wr_ptr_q} + {18'd0, req_len_q};

    always_comb begin
        state_d    = state_q;
        app_req_d  = app_req_q;
        req_addr_d = req_addr_q;
        req_len_d  = req_len_q;
        req_wr_n_d = req_wr_n_q;
        wr_en_n_d  = wr_en_n_q;
        wr_ptr_d   = wr_ptr_q;
        beat_d     = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (w_start) begin
                    req_addr_d = wr_ptr_q;
                    req_len_d  = w_len;
                    req_wr_n_d = 1'b0;
                    app_req_d  = 1'b1;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (app_req_ack) begin
                    app_req_d  = 1'b0;
                    req_wr_n_d = 1'b1;
                    wr_en_n_d  = 4'h0;
                    beat_d     = 9'd0;
                    state_d    = ST_XFER;
                end
            end
            ST_XFER: begin
                if (app_wr_next_req) begin
                    beat_d = w_beat_inc;
                    if (w_beat_inc == req_len_q) begin
                        wr_ptr_d  = (w_ptr_sum == c_ring_end) ? RING_BASE : w_ptr_sum[25:0];
                        wr_en_n_d = 4'hF;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            app_req_q  <= 1'b0;
            req_addr_q <= RING_BASE;
            req_len_q  <= 9'd0;
            req_wr_n_q <= 1'b1;
            wr_en_n_q  <= 4'hF;
            wr_ptr_q   <= RING_BASE;
            beat_q     <= 9'd0;
            level_q    <= '0;
            rd_idx_q   <= '0;
            wr_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            app_req_q  <= app_req_d;
            req_addr_q <= req_addr_d;
            req_len_q  <= req_len_d;
            req_wr_n_q <= req_wr_n_d;
            wr_en_n_q  <= wr_en_n_d;
            wr_ptr_q   <= wr_ptr_d;
            beat_q     <= beat_d;
            level_q    <= level_d;
            rd_idx_q   <= rd_idx_d;
            wr_idx_q   <= wr_idx_d;
        end
    end

    assign in_ready     = (level_q != (c_aw + 1)'(FIFO_DEPTH));
    assign app_req      = app_req_q;
    assign app_req_addr = req_addr_q;
    assign app_req_len  = req_len_q;
    assign app_req_wr_n = req_wr_n_q;
    assign app_wr_en_n  = wr_en_n_q;
    assign app_wr_data  = (level_q == '0) ? 32'h0 : fifo_mem[rd_idx_q];
    assign wr_ptr       = wr_ptr_q;
    assign fifo_level   = level_q;
    assign idle         = (state_q == ST_IDLE) && (level_q == '0);

endmodule
`default_nettype wire
